// File: rtl/alu_defs.sv
// Shared definitions for the ALU sequencer and the decode stage:
// funct codes, ALU select encodings, sequencer states and decode bundle.
package alu_defs;

  localparam int ALU_WIDTH = 24;

  localparam logic [5:0] FN_MULT = 6'h18;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  typedef enum logic [1:0] {
    SEL_AND  = 2'b00,
    SEL_OR   = 2'b01,
    SEL_ADD  = 2'b10,
    SEL_LESS = 2'b11
  } alu_sel_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_EXEC = 3'd1,
    ST_SLT2 = 3'd2,
    ST_MUL  = 3'd3,
    ST_DONE = 3'd4
  } seq_state_e;

  typedef struct packed {
    alu_sel_e sel;
    logic     binv;
    logic     cin;
    logic     is_slt;
    logic     is_sltu;
    logic     is_mul;
    logic     signed_ovf_en;
    logic     illegal;
  } funct_dec_t;

  // Two's-complement overflow from the sign bits of both addends and the sum.
  function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic r_msb);
    return (a_msb == b_msb) && (r_msb != a_msb);
  endfunction

endpackage

// File: rtl/alu_seq_ctrl_if.sv
// Request/response channel between the issue stage (master) and the
// ALU sequencer (slave).
interface alu_seq_ctrl_if #(parameter int WIDTH = 24);

  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic [5:0]       req_funct;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_result;
  logic             rsp_zero;
  logic             rsp_ovf;
  logic             rsp_err;

  modport master (
    output req_valid, req_a, req_b, req_funct, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_zero, rsp_ovf, rsp_err
  );

  modport slave (
    input  req_valid, req_a, req_b, req_funct, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_zero, rsp_ovf, rsp_err
  );

endinterface

// File: rtl/alu_funct_decode.sv
// Combinational MIPS R-type funct decode into ALU controls and op-class flags.
module alu_funct_decode
  import alu_defs::*;
(
  input  logic [5:0] funct,
  output funct_dec_t dec
);

  // Map funct to ALU select/invert/carry and sequencing flags.
  always_comb begin
    dec     = '0;
    dec.sel = SEL_AND;
    case (funct)
      FN_ADD: begin
        dec.sel           = SEL_ADD;
        dec.signed_ovf_en = 1'b1;
      end
      FN_ADDU: begin
        dec.sel = SEL_ADD;
      end
      FN_SUB: begin
        dec.sel           = SEL_ADD;
        dec.binv          = 1'b1;
        dec.cin           = 1'b1;
        dec.signed_ovf_en = 1'b1;
      end
      FN_SUBU: begin
        dec.sel  = SEL_ADD;
        dec.binv = 1'b1;
        dec.cin  = 1'b1;
      end
      FN_SLT: begin
        dec.sel    = SEL_ADD;
        dec.binv   = 1'b1;
        dec.cin    = 1'b1;
        dec.is_slt = 1'b1;
      end
      FN_SLTU: begin
        dec.sel     = SEL_ADD;
        dec.binv    = 1'b1;
        dec.cin     = 1'b1;
        dec.is_sltu = 1'b1;
      end
      FN_AND: begin
        dec.sel = SEL_AND;
      end
      FN_OR: begin
        dec.sel = SEL_OR;
      end
      FN_MULT: begin
        dec.sel    = SEL_ADD;
        dec.is_mul = 1'b1;
      end
      default: begin
        dec.illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Multi-cycle initiator for the external ripple ALU: single-pass ops,
// two-pass SLT/SLTU and a shift-add multiply, with valid/ready handshakes.
module alu_seq_ctrl
  import alu_defs::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  alu_seq_ctrl_if.slave    bus,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_cin,
  output logic             alu_binv,
  output logic [WIDTH-1:0] alu_less,
  output logic             alu_sel1,
  output logic             alu_sel0,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_co
);

  localparam int CNT_W = $clog2(WIDTH);

  seq_state_e       state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [5:0]       funct_q, funct_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lt_q, lt_d;
  logic             req_ready_q, req_ready_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
  logic             rsp_zero_q, rsp_zero_d;
  logic             rsp_ovf_q, rsp_ovf_d;
  logic             rsp_err_q, rsp_err_d;

  logic [5:0]       dec_funct_s;
  funct_dec_t       dec_s;
  logic [WIDTH-1:0] b_eff_s;
  logic             sovf_s;

  // In IDLE the incoming funct is decoded so the first transition can branch on it.
  assign dec_funct_s = (state_q == ST_IDLE) ? bus.req_funct : funct_q;

  alu_funct_decode u_decode (
    .funct (dec_funct_s),
    .dec   (dec_s)
  );

  assign b_eff_s = dec_s.binv ? ~opb_q : opb_q;
  assign sovf_s  = add_ovf(opa_q[WIDTH-1], b_eff_s[WIDTH-1], alu_result[WIDTH-1]);

  // Drive the ALU from state registers; idle states present AND of zeros.
  always_comb begin
    alu_a    = '0;
    alu_b    = '0;
    alu_cin  = 1'b0;
    alu_binv = 1'b0;
    alu_less = '0;
    {alu_sel1, alu_sel0} = SEL_AND;
    case (state_q)
      ST_EXEC: begin
        alu_a    = opa_q;
        alu_b    = opb_q;
        alu_cin  = dec_s.cin;
        alu_binv = dec_s.binv;
        {alu_sel1, alu_sel0} = dec_s.sel;
      end
      ST_SLT2: begin
        alu_less = {{(WIDTH-1){1'b0}}, lt_q};
        {alu_sel1, alu_sel0} = SEL_LESS;
      end
      ST_MUL: begin
        alu_a = acc_q;
        alu_b = opb_q[0] ? opa_q : '0;
        {alu_sel1, alu_sel0} = SEL_ADD;
      end
      default: begin
        alu_less = '0;
      end
    endcase
  end

  // Next-state and response computation.
  always_comb begin
    state_d      = state_q;
    opa_d        = opa_q;
    opb_d        = opb_q;
    acc_d        = acc_q;
    funct_d      = funct_q;
    cnt_d        = cnt_q;
    lt_d         = lt_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    rsp_zero_d   = rsp_zero_q;
    rsp_ovf_d    = rsp_ovf_q;
    rsp_err_d    = rsp_err_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          funct_d   = bus.req_funct;
          opa_d     = bus.req_a;
          opb_d     = bus.req_b;
          acc_d     = '0;
          cnt_d     = '0;
          rsp_ovf_d = 1'b0;
          rsp_err_d = 1'b0;
          if (dec_s.illegal) begin
            state_d      = ST_DONE;
            rsp_err_d    = 1'b1;
            rsp_result_d = '0;
            rsp_zero_d   = 1'b1;
          end else if (dec_s.is_mul) begin
            state_d = ST_MUL;
          end else begin
            state_d = ST_EXEC;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EXEC: begin
        rsp_result_d = alu_result;
        rsp_zero_d   = (alu_result == '0);
        rsp_ovf_d    = dec_s.signed_ovf_en & sovf_s;
        if (dec_s.is_slt || dec_s.is_sltu) begin
          state_d = ST_SLT2;
          lt_d    = dec_s.is_slt ? (alu_result[WIDTH-1] ^ sovf_s) : ~alu_co;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_SLT2: begin
        rsp_result_d = alu_result;
        rsp_zero_d   = (alu_result == '0);
        rsp_ovf_d    = 1'b0;
        state_d      = ST_DONE;
      end
      ST_MUL: begin
        acc_d = alu_result;
        opa_d = opa_q << 1;
        opb_d = opb_q >> 1;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d      = ST_DONE;
          rsp_result_d = alu_result;
          rsp_zero_d   = (alu_result == '0);
          rsp_ovf_d    = 1'b0;
        end else begin
          state_d = ST_MUL;
        end
      end
      ST_DONE: begin
        // rsp_valid rises one cycle after entering DONE and falls only on a handshake.
        if (rsp_valid_q && bus.rsp_ready) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
        end else begin
          state_d     = ST_DONE;
          rsp_valid_d = 1'b1;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        rsp_valid_d = 1'b0;
      end
    endcase
    req_ready_d = (state_d == ST_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      opa_q        <= '0;
      opb_q        <= '0;
      acc_q        <= '0;
      funct_q      <= 6'd0;
      cnt_q        <= '0;
      lt_q         <= 1'b0;
      req_ready_q  <= 1'b1;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
      rsp_ovf_q    <= 1'b0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      opa_q        <= opa_d;
      opb_q        <= opb_d;
      acc_q        <= acc_d;
      funct_q      <= funct_d;
      cnt_q        <= cnt_d;
      lt_q         <= lt_d;
      req_ready_q  <= req_ready_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_zero_q   <= rsp_zero_d;
      rsp_ovf_q    <= rsp_ovf_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_zero   = rsp_zero_q;
  assign bus.rsp_ovf    = rsp_ovf_q;
  assign bus.rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl with a behavioural 24-bit ALU attached.
module tb_alu_seq_ctrl;

  logic        clk;
  logic        rst;
  logic [23:0] alu_a, alu_b, alu_less, alu_result;
  logic        alu_cin, alu_binv, alu_sel1, alu_sel0, alu_co;
  logic [23:0] bb_s;
  logic [24:0] sum_s;

  int n_vec;
  int n_fail;
  int lat;

  alu_seq_ctrl_if #(.WIDTH(24)) bus ();

  alu_seq_ctrl #(.WIDTH(24)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_cin    (alu_cin),
    .alu_binv   (alu_binv),
    .alu_less   (alu_less),
    .alu_sel1   (alu_sel1),
    .alu_sel0   (alu_sel0),
    .alu_result (alu_result),
    .alu_co     (alu_co)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ripple ALU: AND / OR / ADD / LESS on (a, b^binv, cin).
  always_comb begin
    bb_s   = alu_binv ? ~alu_b : alu_b;
    sum_s  = {1'b0, alu_a} + {1'b0, bb_s} + {24'd0, alu_cin};
    alu_co = sum_s[24];
    case ({alu_sel1, alu_sel0})
      2'b00:   alu_result = alu_a & bb_s;
      2'b01:   alu_result = alu_a | bb_s;
      2'b10:   alu_result = sum_s[23:0];
      default: alu_result = alu_less;
    endcase
  end

  task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one request and measure edges from acceptance to rsp_valid.
  task automatic issue(input string tag, input logic [5:0] f, input logic [23:0] a,
                       input logic [23:0] b, input int exp_lat);
    bus.req_valid = 1'b1;
    bus.req_funct = f;
    bus.req_a     = a;
    bus.req_b     = b;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    chk({tag, "/req_ready_busy"}, {23'd0, bus.req_ready}, 24'd0);
    lat = 0;
    while (!bus.rsp_valid && lat < 60) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({tag, "/latency"}, 24'(lat), 24'(exp_lat));
  endtask

  task automatic expect_rsp(input string tag, input logic [23:0] res, input logic z,
                            input logic ovf, input logic err);
    chk({tag, "/result"}, bus.rsp_result, res);
    chk({tag, "/flags"}, {21'd0, bus.rsp_zero, bus.rsp_ovf, bus.rsp_err}, {21'd0, z, ovf, err});
  endtask

  task automatic ack(input string tag);
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
    chk({tag, "/ack_ready"}, {22'd0, bus.req_ready, bus.rsp_valid}, 24'd2);
  endtask

  initial begin
    n_vec         = 0;
    n_fail        = 0;
    rst           = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_a     = 24'd0;
    bus.req_b     = 24'd0;
    bus.req_funct = 6'd0;
    bus.rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    chk("reset/hs", {22'd0, bus.req_ready, bus.rsp_valid}, 24'd2);
    chk("reset/rsp", bus.rsp_result, 24'd0);
    chk("reset/flags", {21'd0, bus.rsp_zero, bus.rsp_ovf, bus.rsp_err}, 24'd0);
    chk("reset/alu_ab", alu_a | alu_b | alu_less, 24'd0);
    chk("reset/alu_ctl", {20'd0, alu_cin, alu_binv, alu_sel1, alu_sel0}, 24'd0);

    issue("add_ovf", 6'h20, 24'h7FFFFF, 24'h000001, 2);
    expect_rsp("add_ovf", 24'h800000, 1'b0, 1'b1, 1'b0);
    chk("done/alu_a", alu_a, 24'd0);
    chk("done/alu_ctl", {20'd0, alu_cin, alu_binv, alu_sel1, alu_sel0}, 24'd0);
    ack("add_ovf");

    issue("sub_zero", 6'h22, 24'h000005, 24'h000005, 2);
    expect_rsp("sub_zero", 24'h000000, 1'b1, 1'b0, 1'b0);
    ack("sub_zero");

    issue("subu", 6'h23, 24'h000000, 24'h000001, 2);
    expect_rsp("subu", 24'hFFFFFF, 1'b0, 1'b0, 1'b0);
    ack("subu");

    issue("addu_wrap", 6'h21, 24'hFFFFFF, 24'h000002, 2);
    expect_rsp("addu_wrap", 24'h000001, 1'b0, 1'b0, 1'b0);
    ack("addu_wrap");

    issue("and", 6'h24, 24'hF0F0F0, 24'h3C3C3C, 2);
    expect_rsp("and", 24'h303030, 1'b0, 1'b0, 1'b0);
    ack("and");

    issue("or", 6'h25, 24'hF0F0F0, 24'h3C3C3C, 2);
    expect_rsp("or", 24'hFCFCFC, 1'b0, 1'b0, 1'b0);
    ack("or");

    issue("slt", 6'h2A, 24'hFFFFFF, 24'h000001, 3);
    expect_rsp("slt", 24'h000001, 1'b0, 1'b0, 1'b0);
    ack("slt");

    issue("sltu", 6'h2B, 24'hFFFFFF, 24'h000001, 3);
    expect_rsp("sltu", 24'h000000, 1'b1, 1'b0, 1'b0);
    ack("sltu");

    issue("mult", 6'h18, 24'h000123, 24'h000045, 25);
    expect_rsp("mult", 24'h004E6F, 1'b0, 1'b0, 1'b0);
    ack("mult");

    issue("mult_wrap", 6'h18, 24'h800000, 24'h000002, 25);
    expect_rsp("mult_wrap", 24'h000000, 1'b1, 1'b0, 1'b0);
    ack("mult_wrap");

    issue("illegal", 6'h3F, 24'h123456, 24'h654321, 1);
    expect_rsp("illegal", 24'h000000, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("bp/hs", {22'd0, bus.req_ready, bus.rsp_valid}, 24'd1);
      chk("bp/rsp", bus.rsp_result, 24'd0);
      chk("bp/err", {23'd0, bus.rsp_err}, 24'd1);
    end
    ack("illegal");

    bus.req_valid = 1'b1;
    bus.req_funct = 6'h18;
    bus.req_a     = 24'h000123;
    bus.req_b     = 24'h000045;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("mid_mul/busy", {22'd0, bus.req_ready, bus.rsp_valid}, 24'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("mid_rst/hs", {22'd0, bus.req_ready, bus.rsp_valid}, 24'd2);
    chk("mid_rst/rsp", bus.rsp_result, 24'd0);
    chk("mid_rst/alu", alu_a | alu_b, 24'd0);

    issue("add_after_rst", 6'h20, 24'h000002, 24'h000003, 2);
    expect_rsp("add_after_rst", 24'h000005, 1'b0, 1'b0, 1'b0);
    ack("add_after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
